// File: rtl/mem_access_stage_pkg.sv
// mem_access_stage_pkg: access size encodings and byte-enable width helper
package mem_access_stage_pkg;
  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_DWORD = 2'b11
  } size_e;
  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction
endpackage

// File: rtl/data_ram_be.sv
// data_ram_be: single-port RAM with per-byte write enables and registered read
module data_ram_be #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic                re_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic [AW-1:0]       addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic [DATA_W-1:0]   rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  // byte-masked write and read-enabled capture; no reset so contents survive rst_n
  always_ff @(posedge clk_i) begin
    if (we_i)
      for (int b = 0; b < DATA_W / 8; b++)
        if (be_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
    if (re_i) rdata_q <= mem_q[addr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: load/store stage with lane select, extension and alignment fault
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
) (
  input  logic              no_clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              misalign
);
  localparam int NB    = be_width(DATA_W);
  localparam int OFFW  = $clog2(NB);
  localparam int DEPTH = 2 ** (ADDR_W - OFFW);
  size_e             sz, sz_q;
  logic [OFFW-1:0]   off, off_q;
  logic              mis, we, re, out_valid_q, mis_q, ld_q, uns_q;
  logic [7:0]        msk8;
  logic [NB-1:0]     be;
  logic [DATA_W-1:0] wdata, rdata, sh, ext;
  logic [6:0]        lsh;
  logic signed [DATA_W-1:0] up;
  assign sz  = size_e'(size);
  assign off = address[OFFW-1:0];
  // a store wins when both read and write are requested; faults block all memory activity
  always_comb begin
    mis   = (mem_read | mem_write) & (sz == SZ_HALF  ? address[0] :
                                      sz == SZ_WORD  ? |address[1:0] :
                                      sz == SZ_DWORD ? (DATA_W == 32) | (|address[2:0]) : 1'b0);
    we    = in_valid & ~stall & mem_write & ~mis;
    re    = in_valid & ~stall & mem_read & ~mem_write & ~mis;
    msk8  = sz == SZ_BYTE ? 8'h01 : sz == SZ_HALF ? 8'h03 : sz == SZ_WORD ? 8'h0F : 8'hFF;
    be    = NB'(msk8) << off;
    wdata = write_data << {off, 3'b000};
  end
  data_ram_be #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk_i  (no_clk),
    .we_i   (we),
    .re_i   (re),
    .be_i   (be),
    .addr_i (address[ADDR_W-1:OFFW]),
    .wdata_i(wdata),
    .rdata_o(rdata)
  );
  // response state; held whole while stalled so RAM read data is also held
  always_ff @(posedge no_clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      mis_q       <= 1'b0;
      ld_q        <= 1'b0;
      off_q       <= '0;
      sz_q        <= SZ_BYTE;
      uns_q       <= 1'b0;
    end else if (!stall) begin
      out_valid_q <= in_valid;
      mis_q       <= in_valid & mis;
      ld_q        <= re;
      off_q       <= off;
      sz_q        <= sz;
      uns_q       <= unsigned_ld;
    end
  end
  // move the selected lanes to the top, then shift back logically or arithmetically
  always_comb begin
    sh  = rdata >> {off_q, 3'b000};
    lsh = 7'(DATA_W) - (7'd8 << sz_q);
    up  = sh << lsh;
    ext = uns_q ? up >> lsh : up >>> lsh;
  end
  assign out_valid = out_valid_q;
  assign misalign  = mis_q;
  assign data_out  = ld_q ? ext : '0;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: vector table, corner sequences and random traffic against a byte-array model
module tb_mem_access_stage;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, stall = 1'b0, mem_read = 1'b0, mem_write = 1'b0, unsigned_ld = 1'b0;
  logic [1:0]  size = 2'd0;
  logic [8:0]  address = 9'd0;
  logic [31:0] write_data = 32'd0, data_out;
  logic        out_valid, misalign;
  logic        iv64 = 1'b0, rd64 = 1'b0, wr64 = 1'b0, un64 = 1'b0, ov64, mis64;
  logic [1:0]  sz64 = 2'd0;
  logic [8:0]  a64 = 9'd0;
  logic [63:0] wd64 = 64'd0, do64;
  int checks = 0, errors = 0;
  logic [7:0]  mem_m [512];
  bit          e_v, e_m;
  logic [31:0] e_d;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .no_clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall),
    .mem_read(mem_read), .mem_write(mem_write), .size(size), .unsigned_ld(unsigned_ld),
    .address(address), .write_data(write_data),
    .out_valid(out_valid), .data_out(data_out), .misalign(misalign)
  );

  mem_access_stage #(.DATA_W(64), .ADDR_W(9)) dut64 (
    .no_clk(clk), .rst_n(rst_n), .in_valid(iv64), .stall(1'b0),
    .mem_read(rd64), .mem_write(wr64), .size(sz64), .unsigned_ld(un64),
    .address(a64), .write_data(wd64),
    .out_valid(ov64), .data_out(do64), .misalign(mis64)
  );

  typedef struct {
    bit v, rd, wr; bit [1:0] sz; bit uns; bit [8:0] a; bit [31:0] wd;
    bit em; bit [31:0] ed; string nm;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  // reference: memory as bytes, results from plain arithmetic on the access rules
  task automatic model(input bit v, input bit rd, input bit wr, input bit [1:0] sz,
                       input bit uns, input bit [8:0] a, input bit [31:0] wd);
    int n;
    logic [63:0] x;
    n = 1 << sz;
    e_v = v; e_m = 1'b0; e_d = 32'd0;
    if (!v) return;
    e_m = (rd | wr) && ((int'(a) % n) != 0 || sz == 2'd3);
    if (e_m) return;
    if (wr) begin
      for (int i = 0; i < n; i++) mem_m[int'(a) + i] = wd[8*i +: 8];
    end else if (rd) begin
      x = 64'd0;
      for (int i = 0; i < n; i++) x |= 64'(mem_m[int'(a) + i]) << (8*i);
      if (!uns && x[8*n-1]) x |= ~64'd0 << (8*n);
      e_d = x[31:0];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input bit v, input bit st, input bit rd, input bit wr, input bit [1:0] sz,
                    input bit uns, input bit [8:0] a, input bit [31:0] wd);
    in_valid = v; stall = st; mem_read = rd; mem_write = wr; size = sz;
    unsigned_ld = uns; address = a; write_data = wd;
    if (!st) model(v, rd, wr, sz, uns, a, wd);
    step();
  endtask

  task automatic go64(input bit v, input bit rd, input bit wr, input bit [1:0] sz,
                      input bit uns, input bit [8:0] a, input bit [63:0] wd);
    iv64 = v; rd64 = rd; wr64 = wr; sz64 = sz; un64 = uns; a64 = a; wd64 = wd;
    step();
  endtask

  task automatic add(input bit v, input bit rd, input bit wr, input bit [1:0] sz, input bit uns,
                     input bit [8:0] a, input bit [31:0] wd, input bit em, input bit [31:0] ed,
                     input string nm);
    vec_t t;
    t.v = v; t.rd = rd; t.wr = wr; t.sz = sz; t.uns = uns; t.a = a; t.wd = wd;
    t.em = em; t.ed = ed; t.nm = nm;
    tbl.push_back(t);
  endtask

  initial begin
    bit [1:0] rsz;
    bit [8:0] ra;
    add(1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 9'h010, 32'hDEADBEEF, 1'b0, 32'h0,        "st_word");
    add(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 9'h010, 32'h0,        1'b0, 32'hDEADBEEF, "ld_word");
    add(1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 9'h013, 32'h00000080, 1'b0, 32'h0,        "st_byte");
    add(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 9'h013, 32'h0,        1'b0, 32'hFFFFFF80, "ld_byte_s");
    add(1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 9'h013, 32'h0,        1'b0, 32'h00000080, "ld_byte_u");
    add(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 9'h010, 32'h0,        1'b0, 32'h80ADBEEF, "ld_word2");
    add(1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 9'h012, 32'h0,        1'b0, 32'hFFFF80AD, "ld_half_s");
    add(1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 9'h011, 32'h0,        1'b1, 32'h0,        "ld_half_mis");
    add(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 9'h010, 32'h0,        1'b0, 32'h80ADBEEF, "ld_word3");
    add(1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 9'h010, 32'h0,        1'b0, 32'h0,        "nonmem");
    add(1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 9'h020, 32'hFFFF1234, 1'b0, 32'h0,        "rdwr_store");
    add(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 9'h020, 32'h0,        1'b0, 32'h00001234, "ld_after_half");
    add(1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 9'h018, 32'h0,        1'b1, 32'h0,        "dword_on_32");
    add(1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 9'h021, 32'hFFFFFFFF, 1'b1, 32'h0,        "st_mis");
    add(1'b1, 1'b1, 1'b0, 2'd2, 1'b1, 9'h020, 32'h0,        1'b0, 32'h00001234, "ld_after_mis");

    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_mis",   64'(misalign),  64'd0);
    chk("rst_data",  64'(data_out),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int w = 0; w < 128; w++) go(1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 9'(w * 4), 32'd0);

    foreach (tbl[i]) begin
      go(tbl[i].v, 1'b0, tbl[i].rd, tbl[i].wr, tbl[i].sz, tbl[i].uns, tbl[i].a, tbl[i].wd);
      chk({tbl[i].nm, "_v"}, 64'(out_valid), 64'(tbl[i].v));
      chk({tbl[i].nm, "_m"}, 64'(misalign),  64'(tbl[i].em));
      chk({tbl[i].nm, "_d"}, 64'(data_out),  64'(tbl[i].ed));
    end
    go(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 9'h0, 32'h0);
    chk("idle_v", 64'(out_valid), 64'd0);
    chk("idle_m", 64'(misalign),  64'd0);

    go(1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 9'h010, 32'h0);
    chk("stall_pre", 64'(data_out), 64'h80ADBEEF);
    for (int k = 0; k < 3; k++) begin
      go(1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 9'h010, 32'h11111111);
      chk("stall_v", 64'(out_valid), 64'd1);
      chk("stall_d", 64'(data_out),  64'h80ADBEEF);
    end
    go(1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 9'h010, 32'h0);
    chk("stall_nowrite", 64'(data_out), 64'h80ADBEEF);

    go(1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 9'h010, 32'h0);
    chk("rst_pre_v", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_v", 64'(out_valid), 64'd0);
    chk("rst_mid_d", 64'(data_out),  64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    e_v = 1'b0;
    go(1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 9'h010, 32'h0);
    chk("rst_after_v", 64'(out_valid), 64'd1);
    chk("rst_after_d", 64'(data_out),  64'h80ADBEEF);
    go(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 9'h0, 32'h0);

    go64(1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 9'h008, 64'h0123456789ABCDEF);
    chk("d64_st_v", 64'(ov64), 64'd1);
    go64(1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 9'h00E, 64'h0);
    chk("d64_half", do64, 64'h0000000000000123);
    go64(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 9'h009, 64'h0);
    chk("d64_byte_s", do64, 64'hFFFFFFFFFFFFFFCD);
    go64(1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 9'h008, 64'h0);
    chk("d64_dword", do64, 64'h0123456789ABCDEF);
    go64(1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 9'h004, 64'h0);
    chk("d64_mis", 64'(mis64), 64'd1);
    chk("d64_mis_d", do64, 64'd0);
    go64(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 9'h0, 64'h0);

    for (int i = 0; i < 500; i++) begin
      rsz = 2'($urandom_range(0, 3));
      ra  = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 3) != 0) ra = ra & ~9'((1 << rsz) - 1);
      go($urandom_range(0, 9) != 0, $urandom_range(0, 6) == 0, 1'($urandom_range(0, 1)),
         1'($urandom_range(0, 1)), rsz, 1'($urandom_range(0, 1)), ra, $urandom);
      chk("rnd_v", 64'(out_valid), 64'(e_v));
      if (e_v) begin
        chk("rnd_m", 64'(misalign), 64'(e_m));
        chk("rnd_d", 64'(data_out), 64'(e_d));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
